// File: rtl/maze_nav_ctrl.sv
// rtl/maze_nav_ctrl.sv - line-tracking maze navigation FSM with filtered tracker input and turn-record stack
module maze_nav_ctrl #(
  parameter int              START_WAIT  = 100_000_000,
  parameter int              FILT_CYC    = 1000,
  parameter int              LOST_CYC    = 200_000,
  parameter int              TURN_TMO    = 300_000_000,
  parameter int              STACK_DEPTH = 16,
  parameter int              DIST_W      = 20,
  parameter logic [DIST_W-1:0] OBST_DIST = 20'd15
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [2:0]                    detect,
  input  logic [DIST_W-1:0]             distance,
  output logic [2:0]                    motor_mode,
  output logic [3:0]                    nav_state,
  output logic [$clog2(STACK_DEPTH):0]  stack_cnt,
  output logic                          done,
  output logic                          err
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILT_CYC + 1);

  localparam logic [2:0] M_STOP  = 3'd0;
  localparam logic [2:0] M_FWD   = 3'd1;
  localparam logic [2:0] M_LEFT  = 3'd2;
  localparam logic [2:0] M_RIGHT = 3'd3;
  localparam logic [2:0] M_SPIN  = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_COUNT  = 4'd2,
    S_FOLLOW = 4'd3,
    S_TURN   = 4'd4,
    S_UTURN  = 4'd5,
    S_RETURN = 4'd6,
    S_HOLD   = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd15
  } state_e;

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  logic [1:0]      dir_q, dir_d;
  logic            arm_q, arm_d;
  logic            jdone_q, jdone_d;
  logic [31:0]     tmr_q, tmr_d;
  logic            tmr_run;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      stk_q [STACK_DEPTH];
  logic            stk_we;
  logic [AW-1:0]   stk_widx;
  logic [1:0]      stk_wdata;
  logic [AW-1:0]   top_idx;
  logic [1:0]      top;
  logic            obst;
  logic            full;

  logic [2:0]      raw_q;
  logic [FW-1:0]   hcnt_q;
  logic [2:0]      filt_q;

  logic [2:0]      motor_q, motor_d;
  logic [3:0]      nav_q;
  logic            done_q;
  logic            err_q;

  function automatic logic [2:0] steer(input logic [2:0] f);
    case (f)
      3'b011, 3'b001: steer = M_RIGHT;
      3'b110, 3'b100: steer = M_LEFT;
      default:        steer = M_FWD;
    endcase
  endfunction

  function automatic logic [2:0] dir2motor(input logic [1:0] d);
    case (d)
      2'b00:   dir2motor = M_LEFT;
      2'b01:   dir2motor = M_FWD;
      default: dir2motor = M_RIGHT;
    endcase
  endfunction

  assign obst    = (distance < OBST_DIST);
  assign full    = (cnt_q == CW'(STACK_DEPTH));
  assign top_idx = AW'(cnt_q - 1'b1);
  assign top     = stk_q[top_idx];

  // The filtered value only follows detect after it has been stable for FILT_CYC cycles.
  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      raw_q  <= 3'b000;
      hcnt_q <= '0;
      filt_q <= 3'b000;
    end else if (detect != raw_q) begin
      raw_q  <= detect;
      hcnt_q <= '0;
    end else if (hcnt_q != FW'(FILT_CYC - 1)) begin
      hcnt_q <= hcnt_q + 1'b1;
    end else begin
      filt_q <= raw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= 2'b00;
    end else if (stk_we) begin
      stk_q[stk_widx] <= stk_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !enable) begin
      state_q <= S_IDLE;
      ret_q   <= S_FOLLOW;
      dir_q   <= 2'b00;
      arm_q   <= 1'b0;
      jdone_q <= 1'b0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      motor_q <= M_STOP;
      nav_q   <= 4'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      dir_q   <= dir_d;
      arm_q   <= arm_d;
      jdone_q <= jdone_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      motor_q <= motor_d;
      nav_q   <= state_q;
      done_q  <= (state_q == S_DONE);
      err_q   <= (state_q == S_ERROR);
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    dir_d     = dir_q;
    arm_d     = arm_q;
    jdone_d   = jdone_q && (filt_q == 3'b111);
    cnt_d     = cnt_q;
    stk_we    = 1'b0;
    stk_widx  = AW'(cnt_q);
    stk_wdata = 2'b00;
    tmr_run   = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_START;
      S_START: if (filt_q == 3'b010) state_d = S_COUNT;
      S_COUNT: begin
        if (tmr_q == 32'(START_WAIT - 1)) state_d = S_FOLLOW;
        else tmr_run = 1'b1;
      end
      S_FOLLOW, S_RETURN: begin
        if (obst) begin
          ret_d   = state_q;
          state_d = S_HOLD;
        end else if (filt_q == 3'b111) begin
          if (state_q == S_FOLLOW) begin
            if (full) begin
              state_d = S_ERROR;
            end else begin
              stk_we  = 1'b1;
              cnt_d   = cnt_q + 1'b1;
              dir_d   = 2'b00;
              arm_d   = 1'b0;
              state_d = S_TURN;
            end
          end else if (!jdone_q) begin
            // Backtracking: advance the top record to its next branch, or drop it once exhausted.
            if (cnt_q == '0) begin
              state_d = S_ERROR;
            end else if (top < 2'b10) begin
              stk_we    = 1'b1;
              stk_widx  = top_idx;
              stk_wdata = top + 2'b01;
              dir_d     = top + 2'b01;
              arm_d     = (top == 2'b00);
              state_d   = S_TURN;
            end else begin
              cnt_d   = cnt_q - 1'b1;
              jdone_d = 1'b1;
            end
          end
        end else if (filt_q == 3'b101) begin
          state_d = S_DONE;
        end else if (filt_q == 3'b000 && state_q == S_FOLLOW) begin
          if (tmr_q == 32'(LOST_CYC - 1)) begin
            state_d = S_UTURN;
            arm_d   = 1'b0;
          end else begin
            tmr_run = 1'b1;
          end
        end
      end
      S_TURN, S_UTURN: begin
        if (filt_q == 3'b000) arm_d = 1'b1;
        if (arm_q && filt_q == 3'b010) state_d = (state_q == S_TURN) ? S_FOLLOW : S_RETURN;
        else if (tmr_q == 32'(TURN_TMO)) state_d = S_ERROR;
        else tmr_run = 1'b1;
      end
      S_HOLD: if (!obst) state_d = ret_q;
      default: ;
    endcase
    tmr_d = (state_d == state_q && tmr_run) ? tmr_q + 32'd1 : 32'd0;
  end

  always_comb begin
    motor_d = M_STOP;
    case (state_q)
      S_FOLLOW, S_RETURN: motor_d = steer(filt_q);
      S_TURN:             motor_d = dir2motor(dir_q);
      S_UTURN:            motor_d = M_SPIN;
      default:            motor_d = M_STOP;
    endcase
  end

  assign motor_mode = motor_q;
  assign nav_state  = nav_q;
  assign stack_cnt  = cnt_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
